// File: rtl/lowpass_fir_fp_seq.sv
// Sequencing controller for a TAP_CNT-tap floating-point lowpass FIR with an external
// delay line, coefficient ROM/RAM and MAC. Define COEF_LOAD_EN to add the coefficient write port.
module lowpass_fir_fp_seq #(
    parameter int TAP_CNT = 31,
    parameter int AW      = 5,
    parameter int MAC_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [31:0]   data_in,
    output logic          ready_in,
    output logic          smp_we,
    output logic [AW-1:0] smp_waddr,
    output logic [31:0]   smp_wdata,
    output logic [AW-1:0] smp_raddr,
    output logic [AW-1:0] coef_raddr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          mac_last,
    input  logic          mac_res_valid,
    input  logic [31:0]   mac_res,
    output logic          valid_out,
    output logic [31:0]   data_out,
    output logic          busy,
    output logic          err
`ifdef COEF_LOAD_EN
    ,
    input  logic          coef_wr_en,
    input  logic [AW-1:0] coef_wr_addr,
    input  logic [31:0]   coef_wr_data,
    output logic          coef_we,
    output logic          coef_wr_ready
`endif
);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    localparam logic [AW-1:0] LAST_IDX  = AW'(TAP_CNT - 1);
    localparam logic [AW-1:0] TAP_MOD   = AW'(TAP_CNT);
    localparam int            DCW       = $clog2(MAC_LAT + 2) + 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MAC_LAT + 1);

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   newest_q;
    logic [AW-1:0]   k_q;
    logic [DCW-1:0]  drain_q;
    logic [31:0]     data_q;
    logic            err_q;

    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_idx_d;
    logic            accept;
    logic            issuing;

    assign accept   = !rst && (state_q == IDLE) && valid_in;
    assign issuing  = !rst && (state_q == ISSUE);
    assign wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + AW'(1);

    // (newest - k) mod TAP_CNT; the AW-bit wraparound cancels when TAP_MOD is added back.
    assign rd_idx_d = (newest_q >= k_q) ? (newest_q - k_q) : (newest_q - k_q + TAP_MOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            wr_ptr_q <= '0;
            newest_q <= '0;
            k_q      <= '0;
            drain_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (k_q == LAST_IDX) begin
                        k_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                IDLE: begin
                    if (valid_in) begin
                        newest_q <= wr_ptr_q;
                        wr_ptr_q <= wr_ptr_d;
                        k_q      <= '0;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k_q == LAST_IDX) begin
                        k_q     <= '0;
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                DRAIN: begin
                    // A late result on the final DRAIN cycle still wins over the timeout.
                    if (mac_res_valid) begin
                        data_q  <= mac_res;
                        state_q <= OUT;
                    end else if (drain_q == DRAIN_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        drain_q <= drain_q + DCW'(1);
                    end
                end
                OUT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    // Strobes are gated with rst so a reset cycle never issues memory or MAC traffic.
    assign ready_in   = !rst && (state_q == IDLE);
    assign smp_we     = (!rst && (state_q == CLEAR)) || accept;
    assign smp_waddr  = (state_q == CLEAR) ? k_q : wr_ptr_q;
    assign smp_wdata  = accept ? data_in : '0;
    assign mac_en     = issuing;
    assign coef_raddr = issuing ? k_q : '0;
    assign smp_raddr  = issuing ? rd_idx_d : '0;
    assign mac_first  = issuing && (k_q == '0);
    assign mac_last   = issuing && (k_q == LAST_IDX);
    assign valid_out  = !rst && (state_q == OUT);
    assign data_out   = rst ? '0 : data_q;
    assign busy       = rst || (state_q != IDLE);
    assign err        = !rst && err_q;

`ifdef COEF_LOAD_EN
    assign coef_wr_ready = !rst && (state_q == IDLE) && !valid_in;
    assign coef_we       = coef_wr_en && coef_wr_ready && (coef_wr_addr <= LAST_IDX);
`endif

endmodule

// File: tb/tb_lowpass_fir_fp_seq.sv
// Directed-plus-random bench for lowpass_fir_fp_seq; reference model tracks sample history
// and expected addressing arithmetically. Define COEF_LOAD_EN to exercise the coefficient port.
module tb_lowpass_fir_fp_seq;

    localparam int TAP_CNT = 31;
    localparam int AW      = 5;
    localparam int MAC_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid_in, mac_res_valid;
    logic [31:0]   data_in, mac_res;
    logic          ready_in, smp_we, mac_en, mac_first, mac_last, valid_out, busy, err;
    logic [AW-1:0] smp_waddr, smp_raddr, coef_raddr;
    logic [31:0]   smp_wdata, data_out;
`ifdef COEF_LOAD_EN
    logic          coef_wr_en, coef_we, coef_wr_ready;
    logic [AW-1:0] coef_wr_addr;
    logic [31:0]   coef_wr_data;
`endif

    lowpass_fir_fp_seq #(.TAP_CNT(TAP_CNT), .AW(AW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
        .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata), .smp_raddr(smp_raddr),
        .coef_raddr(coef_raddr), .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
        .mac_res_valid(mac_res_valid), .mac_res(mac_res), .valid_out(valid_out),
        .data_out(data_out), .busy(busy), .err(err)
`ifdef COEF_LOAD_EN
        , .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .coef_we(coef_we), .coef_wr_ready(coef_wr_ready)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural delay-line memory fed by the DUT's write port.
    logic [31:0] tbmem [TAP_CNT];
    always @(posedge clk) if (smp_we && (int'(smp_waddr) < TAP_CNT)) tbmem[smp_waddr] <= smp_wdata;

    int coef_pulses = 0;
`ifdef COEF_LOAD_EN
    always @(posedge clk) if (coef_we) coef_pulses <= coef_pulses + 1;
`endif

    // Reference model state
    int          n_acc = 0;
    logic [31:0] hist[$];
    logic [31:0] exp_dout = 32'h0;
    logic        exp_err = 1'b0;
    bit          coef_hold = 1'b0;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in the first CLEAR cycle with rst already low.
    task automatic clear_check;
        for (int i = 0; i < TAP_CNT; i++) begin
            if (i > 0) tick;
            #1;
            chk("clr_we", 32'(smp_we), 32'd1);
            chk("clr_waddr", 32'(smp_waddr), 32'(i));
            chk("clr_wdata", smp_wdata, 32'h0);
            chk("clr_ready", 32'(ready_in), 32'd0);
        end
        tick;
        #1;
        chk("idle_ready", 32'(ready_in), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        n_acc = 0;
        hist.delete();
        exp_dout = 32'h0;
        exp_err = 1'b0;
    endtask

    // Entered in an IDLE cycle; leaves in the following IDLE cycle (or CLEAR+IDLE after reset).
    task automatic sample(input logic [31:0] d, input int delay, input logic [31:0] res,
                          input bit timeout, input int rst_at);
        int newest, t0, nd, exp_ra;
        logic [31:0] tap_obs, tap_exp;
        newest = n_acc % TAP_CNT;
        valid_in = 1'b1;
        data_in = d;
        mac_res_valid = 1'($urandom_range(1, 0));
        mac_res = $urandom;
        #1;
        chk("acc_ready", 32'(ready_in), 32'd1);
        chk("acc_we", 32'(smp_we), 32'd1);
        chk("acc_waddr", 32'(smp_waddr), 32'(newest));
        chk("acc_wdata", smp_wdata, d);
`ifdef COEF_LOAD_EN
        if (coef_hold) begin
            chk("coef_we_acc", 32'(coef_we), 32'd0);
            chk("coef_rdy_acc", 32'(coef_wr_ready), 32'd0);
        end
`endif
        t0 = cyc;
        hist.push_front(d);
        if (hist.size() > TAP_CNT) hist.delete(hist.size() - 1);
        n_acc++;
        tick;
        for (int k = 0; k < TAP_CNT; k++) begin
            if (k > 0) tick;
            if (k == rst_at) begin
                rst = 1'b1;
                valid_in = 1'b0;
                mac_res_valid = 1'b0;
                #1;
                chk("rst_mac_en_now", 32'(mac_en), 32'd0);
                tick;
                #1;
                chk("rst_mac_en", 32'(mac_en), 32'd0);
                chk("rst_we", 32'(smp_we), 32'd0);
                chk("rst_ready", 32'(ready_in), 32'd0);
                chk("rst_busy", 32'(busy), 32'd1);
                chk("rst_err", 32'(err), 32'd0);
                chk("rst_dout", data_out, 32'h0);
                chk("rst_vout", 32'(valid_out), 32'd0);
                rst = 1'b0;
                clear_check();
                return;
            end
            valid_in = 1'($urandom_range(1, 0));
            data_in = $urandom;
            mac_res_valid = ((k % 7) == 3);
            mac_res = $urandom;
            #1;
            exp_ra = (newest - k + TAP_CNT) % TAP_CNT;
            tap_obs = (int'(smp_raddr) < TAP_CNT) ? tbmem[smp_raddr] : 32'hxxxxxxxx;
            tap_exp = (k < hist.size()) ? hist[k] : 32'h0;
            chk("iss_mac_en", 32'(mac_en), 32'd1);
            chk("iss_coef_raddr", 32'(coef_raddr), 32'(k));
            chk("iss_smp_raddr", 32'(smp_raddr), 32'(exp_ra));
            chk("iss_first", 32'(mac_first), 32'(k == 0));
            chk("iss_last", 32'(mac_last), 32'(k == TAP_CNT - 1));
            chk("iss_tap", tap_obs, tap_exp);
            chk("iss_we", 32'(smp_we), 32'd0);
            chk("iss_ready", 32'(ready_in), 32'd0);
            if (k == 0) begin
                chk("iss_dout_held", data_out, exp_dout);
                chk("iss_err", 32'(err), 32'(exp_err));
            end
`ifdef COEF_LOAD_EN
            if (coef_hold) chk("coef_we_iss", 32'(coef_we), 32'd0);
`endif
        end
        nd = timeout ? (MAC_LAT + 2) : delay;
        for (int j = 0; j < nd; j++) begin
            tick;
            valid_in = 1'($urandom_range(1, 0));
            mac_res_valid = 1'b0;
            #1;
            chk("drn_mac_en", 32'(mac_en), 32'd0);
            chk("drn_vout", 32'(valid_out), 32'd0);
            chk("drn_busy", 32'(busy), 32'd1);
            chk("drn_we", 32'(smp_we), 32'd0);
`ifdef COEF_LOAD_EN
            if (coef_hold) chk("coef_we_drn", 32'(coef_we), 32'd0);
`endif
        end
        tick;
        valid_in = 1'b0;
        if (timeout) begin
            mac_res_valid = 1'b0;
            #1;
            exp_err = 1'b1;
            chk("to_err", 32'(err), 32'd1);
            chk("to_vout", 32'(valid_out), 32'd0);
            chk("to_ready", 32'(ready_in), 32'd1);
            chk("to_dout", data_out, exp_dout);
            return;
        end
        mac_res_valid = 1'b1;
        mac_res = res;
        #1;
        chk("cap_vout", 32'(valid_out), 32'd0);
        tick;
        mac_res_valid = 1'b1;
        mac_res = ~res;
        #1;
        exp_dout = res;
        chk("out_vout", 32'(valid_out), 32'd1);
        chk("out_dout", data_out, res);
        chk("out_latency", 32'(cyc - t0), 32'(TAP_CNT + 2 + nd));
`ifdef COEF_LOAD_EN
        if (coef_hold) chk("coef_we_out", 32'(coef_we), 32'd0);
`endif
        tick;
        mac_res_valid = 1'b0;
        #1;
        chk("post_vout", 32'(valid_out), 32'd0);
        chk("post_ready", 32'(ready_in), 32'd1);
        chk("post_dout", data_out, res);
        chk("post_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        data_in = 32'h0;
        mac_res_valid = 1'b0;
        mac_res = 32'h0;
`ifdef COEF_LOAD_EN
        coef_wr_en = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = 32'h0;
`endif
        repeat (3) tick;
        #1;
        chk("reset_ready", 32'(ready_in), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_we", 32'(smp_we), 32'd0);
        chk("reset_mac_en", 32'(mac_en), 32'd0);
        chk("reset_vout", 32'(valid_out), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_dout", data_out, 32'h0);
        rst = 1'b0;
        clear_check();

        sample(32'h3F800000, 0, 32'h3E000000, 1'b0, -1);
        sample($urandom, MAC_LAT + 1, $urandom, 1'b0, -1);
        for (int i = 2; i < 40; i++) begin
            sample($urandom, $urandom_range(MAC_LAT + 1, 0), $urandom, 1'b0, -1);
            repeat ($urandom_range(2, 0)) tick;
        end
        sample($urandom, 0, 32'h0, 1'b1, -1);
        sample($urandom, $urandom_range(MAC_LAT + 1, 0), $urandom, 1'b0, -1);
        sample($urandom, 10, 32'h0, 1'b0, 10);
        sample(32'h40400000, 1, 32'hC0A00000, 1'b0, -1);
        sample($urandom, 2, $urandom, 1'b0, -1);

`ifdef COEF_LOAD_EN
        begin
            int p0;
            p0 = coef_pulses;
            coef_hold = 1'b1;
            coef_wr_en = 1'b1;
            coef_wr_addr = 5'd3;
            coef_wr_data = $urandom;
            sample($urandom, 1, $urandom, 1'b0, -1);
            chk("coef_rdy_idle", 32'(coef_wr_ready), 32'd1);
            chk("coef_we_idle", 32'(coef_we), 32'd1);
            tick;
            coef_wr_en = 1'b0;
            coef_hold = 1'b0;
            #1;
            chk("coef_pulses", 32'(coef_pulses - p0), 32'd1);
            coef_wr_en = 1'b1;
            coef_wr_addr = 5'd31;
            #1;
            chk("coef_oor_rdy", 32'(coef_wr_ready), 32'd1);
            chk("coef_oor_we", 32'(coef_we), 32'd0);
            tick;
            coef_wr_en = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lowpass_fir_fp_seq.md
LOWPASS_FIR_FP_SEQ -- requirements
Module: lowpass_fir_fp_seq

Interface
REQ-001 The module SHALL have parameter TAP_CNT, default 31: number of FIR taps and delay-line depth.
REQ-002 The module SHALL have parameter AW, default 5: address width, with 2^AW >= TAP_CNT.
REQ-003 The module SHALL have parameter MAC_LAT, default 4: nominal MAC result latency in cycles after the last issued tap.
REQ-004 The module SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  input sample strobe.
- data_in  in  32  IEEE-754 single-precision sample.
- ready_in  out  1  controller can accept a sample this cycle.
- smp_we  out  1  delay-line write strobe.
- smp_waddr  out  AW  delay-line write address.
- smp_wdata  out  32  delay-line write data.
- smp_raddr  out  AW  delay-line read address.
- coef_raddr  out  AW  coefficient read address (tap index).
- mac_en  out  1  MAC issue strobe.
- mac_first  out  1  first tap of a sum; MAC clears its accumulator.
- mac_last  out  1  last tap of a sum.
- mac_res_valid  in  1  MAC final-sum strobe.
- mac_res  in  32  MAC final sum, IEEE-754.
- valid_out  out  1  one-cycle output strobe.
- data_out  out  32  filtered sample, held between strobes.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky MAC timeout flag.

Function
REQ-005 The FSM SHALL have states CLEAR, IDLE, ISSUE, DRAIN and OUT.
REQ-006 CLEAR SHALL write 32'h0 to addresses 0..TAP_CNT-1, one per cycle, with smp_we=1 and ready_in=0, then go to IDLE.
REQ-007 In IDLE, ready_in SHALL be 1; valid_in && ready_in SHALL, in that cycle, drive smp_we=1, smp_waddr=wr_ptr and smp_wdata=data_in, latch newest=wr_ptr, advance wr_ptr (mod TAP_CNT, TAP_CNT-1 wraps to 0) and go to ISSUE.
REQ-008 valid_in SHALL be ignored whenever ready_in=0; no sample is buffered.
REQ-009 ISSUE SHALL last exactly TAP_CNT cycles, k=0..TAP_CNT-1, and in cycle k drive:
- mac_en=1, coef_raddr=k
- smp_raddr=(newest-k) mod TAP_CNT
- mac_first=(k==0), mac_last=(k==TAP_CNT-1)
REQ-010 After ISSUE the FSM SHALL go to DRAIN; mac_en, mac_first and mac_last SHALL be 0 outside ISSUE.
REQ-011 In DRAIN, mac_res_valid=1 SHALL capture mac_res into data_out and go to OUT.
REQ-012 mac_res_valid SHALL be ignored in every state other than DRAIN, including one arriving during ISSUE.
REQ-013 OUT SHALL assert valid_out for exactly one cycle, then go to IDLE.
REQ-014 Minimum accept-to-valid_out latency SHALL be TAP_CNT+2 cycles (mac_res_valid on the first DRAIN cycle); actual latency is TAP_CNT+2+MAC response delay.
REQ-015 If DRAIN lasts MAC_LAT+2 cycles without mac_res_valid, err SHALL set, data_out SHALL be unchanged, no valid_out SHALL be produced, and the FSM SHALL go to IDLE.
REQ-016 err SHALL clear only on rst.

Reset
REQ-017 rst SHALL force the following, next state CLEAR, taking priority over all other inputs, including mid-ISSUE or mid-DRAIN:
- wr_ptr=0, newest=0, k=0
- data_out=0, valid_out=0, err=0
- ready_in=0, busy=1
- all memory and MAC strobes 0

Configuration
REQ-018 With COEF_LOAD_EN defined, the module SHALL add:
- coef_wr_en  in  1  coefficient write request.
- coef_wr_addr  in  AW  coefficient write address.
- coef_wr_data  in  32  coefficient write data.
- coef_we  out  1  coefficient memory write strobe.
- coef_wr_ready  out  1  coefficient write accepted this cycle.
REQ-019 With COEF_LOAD_EN defined, coef_wr_ready SHALL be 1 only in IDLE with valid_in=0.
REQ-020 With COEF_LOAD_EN defined, coef_we=coef_wr_en&&coef_wr_ready; otherwise the request stalls until accepted.
REQ-021 With COEF_LOAD_EN defined, writes with coef_wr_addr>=TAP_CNT SHALL be dropped while coef_wr_ready still pulses.
REQ-022 Without COEF_LOAD_EN, these ports SHALL be absent and coefficients are fixed.

Verification (TAP_CNT=31, MAC_LAT=4)
REQ-023 The bench SHALL cover at least these scenarios:
- Deassert rst -> 31 cycles smp_we=1, smp_waddr 0..30, smp_wdata=0, ready_in=0; ready_in=1 on cycle 32.
- First sample 32'h3F800000 -> smp_waddr=0; smp_raddr 0,30,29..1; mac_first in cycle 1 only, mac_last in cycle 31 only; mac_res_valid=1 with 32'h3E000000 on the first DRAIN cycle -> valid_out for 1 cycle, data_out=32'h3E000000, 33 cycles after accept.
- 31 samples, then a 32nd -> written at smp_waddr=0, read sequence starts 0,30; second-sample read sequence starts 1,0,30.
- mac_res_valid withheld -> err=1 after 6 DRAIN cycles, no valid_out, ready_in=1 next cycle.
- rst pulsed at ISSUE k=10 -> mac_en=0 next cycle and CLEAR restarts at smp_waddr=0.
- COEF_LOAD_EN: coef_wr_en held during ISSUE -> coef_we=0 until IDLE, then exactly one coef_we pulse.
